// File: rtl/grid_read_arbiter.sv
// Shares one grid BRAM read port between a solver (absolute priority, never stalled)
// and a full-grid dump streamed out over AXI-stream through a credit-limited FIFO.
package grid_pkg;
   localparam int GRID_ADDRWIDTH = 4;
endpackage

module grid_read_arbiter #(
   parameter int ADDRWIDTH = grid_pkg::GRID_ADDRWIDTH,
   parameter int DWIDTH    = 16,
   parameter int NCELLS    = 2**ADDRWIDTH,
   parameter int RD_LAT    = 2,
   parameter int DEPTH     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sol_req,
   input  logic [ADDRWIDTH-1:0] sol_addr,
   output logic                 sol_valid,
   output logic [DWIDTH-1:0]    sol_data,
   input  logic                 dump_start,
   output logic                 dump_busy,
   output logic                 dump_done,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic [DWIDTH-1:0]    m_tdata,
   output logic                 m_tlast,
   output logic                 mem_en,
   output logic [ADDRWIDTH-1:0] mem_addr,
   input  logic [DWIDTH-1:0]    mem_data
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NCELLS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_e;
   typedef enum logic [1:0] {TAG_NONE, TAG_SOL, TAG_DUMP} tag_e;

   state_e               state_q, state_d;
   logic [ADDRWIDTH-1:0] addr_q, addr_d;
   tag_e                 tag_q [RD_LAT];
   tag_e                 tag_d [RD_LAT];
   logic                 last_tag_q [RD_LAT];
   logic                 last_tag_d [RD_LAT];
   logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]        count_q, count_d, inflight_q, inflight_d;
   logic [DWIDTH-1:0]    buf_data_q [DEPTH];
   logic                 buf_last_q [DEPTH];
   logic                 done_q, done_d;

   logic dump_issue, ret_sol, ret_dump, buf_wr, buf_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credit check counts reads still in the memory pipe so the FIFO can never overflow.
   assign dump_issue = (state_q == S_SCAN) && !sol_req &&
                       (((CW+1)'(count_q) + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH));
   assign ret_sol    = (tag_q[RD_LAT-1] == TAG_SOL);
   assign ret_dump   = (tag_q[RD_LAT-1] == TAG_DUMP);
   assign buf_wr     = ret_dump;
   assign buf_pop    = m_tvalid && m_tready;

   assign mem_en    = sol_req || dump_issue;
   assign mem_addr  = sol_req ? sol_addr : addr_q;
   assign sol_valid = ret_sol;
   assign sol_data  = mem_data;
   assign m_tvalid  = (count_q != '0);
   assign m_tdata   = buf_data_q[rptr_q];
   assign m_tlast   = m_tvalid && buf_last_q[rptr_q];
   assign dump_busy = (state_q != S_IDLE);
   assign dump_done = done_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      done_d     = 1'b0;

      tag_d[0]      = sol_req ? TAG_SOL : (dump_issue ? TAG_DUMP : TAG_NONE);
      last_tag_d[0] = dump_issue && (addr_q == LAST_ADDR);
      for (int i = 1; i < RD_LAT; i++) begin
         tag_d[i]      = tag_q[i-1];
         last_tag_d[i] = last_tag_q[i-1];
      end

      if (dump_issue && !ret_dump)      inflight_d = inflight_q + CW'(1);
      else if (!dump_issue && ret_dump) inflight_d = inflight_q - CW'(1);

      if (buf_wr)             wptr_d  = ptr_inc(wptr_q);
      if (buf_pop)            rptr_d  = ptr_inc(rptr_q);
      if (buf_wr && !buf_pop) count_d = count_q + CW'(1);
      else if (!buf_wr && buf_pop) count_d = count_q - CW'(1);

      case (state_q)
         S_IDLE: begin
            if (dump_start) begin
               state_d = S_SCAN;
               addr_d  = '0;
            end
         end
         S_SCAN: begin
            if (dump_issue) begin
               addr_d = addr_q + ADDRWIDTH'(1);
               if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (buf_pop && buf_last_q[rptr_q]) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         done_q     <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i]      <= TAG_NONE;
            last_tag_q[i] <= 1'b0;
         end
         for (int i = 0; i < DEPTH; i++) begin
            buf_data_q[i] <= '0;
            buf_last_q[i] <= 1'b0;
         end
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_q[i]      <= tag_d[i];
            last_tag_q[i] <= last_tag_d[i];
         end
         if (buf_wr) begin
            buf_data_q[wptr_q] <= mem_data;
            buf_last_q[wptr_q] <= last_tag_q[RD_LAT-1];
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(buf_wr && !buf_pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_grid_read_arbiter.sv
// Randomized bench for grid_read_arbiter: a BRAM model with fixed latency feeds the DUT,
// expected solver words and dump beats come from the grid contents and are checked by a monitor.
module tb_grid_read_arbiter;
   localparam int AW = 4;
   localparam int DW = 16;
   localparam int NC = 16;
   localparam int RL = 2;
   localparam int DP = 8;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } sol_t;

   logic          clk, rst_n;
   logic          sol_req, sol_valid, dump_start, dump_busy, dump_done;
   logic [AW-1:0] sol_addr, mem_addr;
   logic [DW-1:0] sol_data, m_tdata, mem_data;
   logic          m_tvalid, m_tready, m_tlast, mem_en;

   logic [DW-1:0] grid [NC];
   logic [DW-1:0] dp [RL];
   sol_t          sol_q[$];
   logic [DW:0]   exp_q[$];

   int   tests = 0, fails = 0, cyc = 0;
   int   beats_seen = 0, done_count = 0, dump_issues = 0;
   bit   done_pending = 0, prev_stall = 0;
   logic [DW:0] prev_beat = '0;

   grid_read_arbiter #(.ADDRWIDTH(AW), .DWIDTH(DW), .NCELLS(NC), .RD_LAT(RL), .DEPTH(DP)) dut (
      .clk(clk), .rst_n(rst_n), .sol_req(sol_req), .sol_addr(sol_addr),
      .sol_valid(sol_valid), .sol_data(sol_data), .dump_start(dump_start),
      .dump_busy(dump_busy), .dump_done(dump_done), .m_tvalid(m_tvalid),
      .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data)
   );

   // Clock, cycle counter and fixed-latency BRAM model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      dp[0] <= grid[mem_addr];
      for (int i = RL - 1; i > 0; i--) dp[i] <= dp[i-1];
   end
   assign mem_data = dp[RL-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      logic [DW:0] e;
      if (sol_q.size() > 0 && sol_q[0].due == cyc) begin
         check("sol_valid", 64'(sol_valid), 64'd1);
         check("sol_data", 64'(sol_data), 64'(sol_q[0].data));
         void'(sol_q.pop_front());
      end else if (sol_valid) begin
         check("sol_valid_spurious", 64'(sol_valid), 64'd0);
      end

      if (sol_req) begin
         check("mem_en_sol", 64'(mem_en), 64'd1);
         check("mem_addr_sol", 64'(mem_addr), 64'(sol_addr));
      end else if (!dump_busy) begin
         check("mem_en_idle", 64'(mem_en), 64'd0);
      end
      if (mem_en && !sol_req) dump_issues++;

      if (dump_done || done_pending) begin
         check("dump_done", 64'(dump_done), 64'(done_pending));
         if (dump_done) done_count++;
      end
      done_pending = 0;

      if (rst_n && prev_stall) begin
         check("m_tvalid_hold", 64'(m_tvalid), 64'd1);
         check("m_beat_hold", 64'({m_tlast, m_tdata}), 64'(prev_beat));
      end
      prev_stall = rst_n && m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};

      if (m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL beat_extra: got beat %0h with no beat expected (cycle %0d)",
                     {m_tlast, m_tdata}, cyc);
         end else begin
            e = exp_q.pop_front();
            check("beat", 64'({m_tlast, m_tdata}), 64'(e));
            beats_seen++;
            if (e[DW]) done_pending = 1;
         end
      end
   end

   // Driver tasks
   task automatic randomize_grid();
      for (int i = 0; i < NC; i++) grid[i] = DW'($urandom);
   endtask

   task automatic drive_cycle(input bit sreq, input logic [AW-1:0] saddr, input bit rdy);
      @(posedge clk);
      #1;
      dump_start = 1'b0;
      sol_req    = sreq;
      sol_addr   = saddr;
      m_tready   = rdy;
      if (sreq) sol_q.push_back('{due: cyc + RL, data: grid[saddr]});
   endtask

   task automatic start_dump();
      @(posedge clk);
      #1;
      dump_start = 1'b1;
      sol_req    = 1'b0;
      for (int i = 0; i < NC; i++) exp_q.push_back({(i == NC - 1), grid[i]});
   endtask

   // mode 0: no solver, ready high; 1: solver every other cycle; 2: random solver and ready
   task automatic finish_dump(input int mode);
      int  d0;
      bit  ended;
      d0    = done_count;
      ended = 0;
      for (int c = 0; c < 3000; c++) begin
         case (mode)
            0:       drive_cycle(1'b0, '0, 1'b1);
            1:       drive_cycle(c[0], AW'($urandom_range(0, NC - 1)), 1'b1);
            default: drive_cycle($urandom_range(0, 2) == 0, AW'($urandom_range(0, NC - 1)),
                                 $urandom_range(0, 3) != 0);
         endcase
         if (!dump_busy && exp_q.size() == 0) begin
            ended = 1;
            break;
         end
      end
      if (!ended) begin
         tests++;
         fails++;
         $display("FAIL dump_timeout: got %0d beats still pending expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (RL + 2) drive_cycle(1'b0, '0, 1'b1);
      check("sol_drained", 64'(sol_q.size()), 64'd0);
      check("done_count", 64'(done_count), 64'(d0 + 1));
      check("busy_after", 64'(dump_busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      int b0, d0;
      rst_n = 1'b0; sol_req = 1'b0; sol_addr = '0; dump_start = 1'b0; m_tready = 1'b1;
      randomize_grid();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sol_valid", 64'(sol_valid), 64'd0);
      check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_m_tlast", 64'(m_tlast), 64'd0);
      check("rst_dump_busy", 64'(dump_busy), 64'd0);
      check("rst_dump_done", 64'(dump_done), 64'd0);
      check("rst_mem_en", 64'(mem_en), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Solver burst at 5,6,7
      drive_cycle(1'b1, AW'(5), 1'b1);
      drive_cycle(1'b1, AW'(6), 1'b1);
      drive_cycle(1'b1, AW'(7), 1'b1);
      repeat (4) drive_cycle(1'b0, '0, 1'b1);
      check("burst_drained", 64'(sol_q.size()), 64'd0);

      // Plain dump
      dump_issues = 0;
      start_dump();
      finish_dump(0);
      check("dump_issues", 64'(dump_issues), 64'(NC));

      // Dump interleaved with solver traffic
      randomize_grid();
      start_dump();
      finish_dump(1);

      // Back-pressure: sink stalls for 20 cycles
      drive_cycle(1'b0, '0, 1'b0);
      dump_issues = 0;
      start_dump();
      repeat (20) drive_cycle(1'b0, '0, 1'b0);
      check("sat_issues", 64'(dump_issues), 64'(DP));
      check("sat_tvalid", 64'(m_tvalid), 64'd1);
      finish_dump(0);

      // Second start during SCAN is ignored
      randomize_grid();
      start_dump();
      repeat (3) drive_cycle(1'b0, '0, 1'b1);
      @(posedge clk);
      #1 dump_start = 1'b1;
      finish_dump(0);

      // Randomized dumps
      repeat (3) begin
         randomize_grid();
         start_dump();
         finish_dump(2);
      end

      // Reset after beat 7, then a clean restart
      randomize_grid();
      b0 = beats_seen;
      d0 = done_count;
      start_dump();
      for (int c = 0; c < 200; c++) begin
         drive_cycle(1'b0, '0, 1'b1);
         if (beats_seen - b0 >= 7) break;
      end
      check("beats_before_reset", 64'(beats_seen - b0), 64'd7);
      rst_n    = 1'b0;
      m_tready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_tvalid", 64'(m_tvalid), 64'd0);
      check("abort_busy", 64'(dump_busy), 64'd0);
      check("abort_done", 64'(dump_done), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      m_tready = 1'b1;
      repeat (RL + 2) drive_cycle(1'b0, '0, 1'b1);
      check("abort_no_done", 64'(done_count), 64'(d0));
      randomize_grid();
      start_dump();
      finish_dump(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
